// File: rtl/sha_target_check_pkg.sv
// Shared widths and helpers for sha_target_check: hash word slicing and
// the word-wise "H <= target" resolution used by the compare pipeline.
package sha_target_check_pkg;

    localparam int WORD_S      = 32;
    localparam int H_SIZE      = 256;
    localparam int N_WORDS     = H_SIZE / WORD_S;
    localparam int HIT_ENTRY_S = 64;

    function automatic logic [WORD_S-1:0] vec_i(input logic [H_SIZE-1:0] v, input int i);
        return v[i*WORD_S +: WORD_S];
    endfunction

    // Walk from word 0 upward so the most significant word has the final say.
    function automatic logic resolve_hit(input logic [N_WORDS-1:0] eq,
                                         input logic [N_WORDS-1:0] lt);
        logic hit;
        hit = 1'b1;
        for (int i = 0; i < N_WORDS; i++) begin
            hit = lt[i] | (eq[i] & hit);
        end
        return hit;
    endfunction

endpackage

// File: rtl/sha_hit_fifo.sv
// Small FIFO for winning hashes: push/pop handshake, synchronous flush,
// and a drop pulse when a push meets a full FIFO with no pop.
module sha_hit_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic             drop
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    logic empty;
    logic full;
    logic pop;
    logic wr_ok;

    always_comb begin
        empty = (count_q == '0);
        full  = (count_q == FULL_CNT);
        pop   = !empty & pop_ready;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        wr_ok = push & (!full | pop);
        drop  = push & full & !pop & !clear;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;

        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_ok) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            count_d = count_q + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    assign head_valid = !empty;
    assign head_data  = mem_q[rd_ptr_q];

endmodule

// File: rtl/sha_target_check.sv
// Two-stage H <= target comparator behind sha_block, with a hit FIFO and a
// saturating hash counter. Optional halt-on-first-hit: SHA_TARGET_STOP_ON_HIT_EN.
module sha_target_check
    import sha_target_check_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 48
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              en,
    input  logic [31:0]       nonce,
    input  logic [H_SIZE-1:0] H,
    input  logic [H_SIZE-1:0] target,
    output logic              hit_valid,
    input  logic              hit_ready,
    output logic [31:0]       hit_nonce,
    output logic [31:0]       hit_hword,
    output logic [CNT_W-1:0]  hash_count,
`ifdef SHA_TARGET_STOP_ON_HIT_EN
    output logic              halted,
`endif
    output logic              overflow
);

    logic en_acc;

    logic                   v1_q, v1_d;
    logic [N_WORDS-1:0]     eq_q, eq_d;
    logic [N_WORDS-1:0]     lt_q, lt_d;
    logic [31:0]            nonce1_q, nonce1_d;
    logic [WORD_S-1:0]      hword1_q, hword1_d;

    logic                   v2_q, v2_d;
    logic [HIT_ENTRY_S-1:0] entry2_q, entry2_d;

    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   overflow_q, overflow_d;
    logic                   fifo_drop;
    logic [HIT_ENTRY_S-1:0] head_data;

`ifdef SHA_TARGET_STOP_ON_HIT_EN
    logic halted_q, halted_d;
    assign en_acc = en & !clear & !halted_q;
`else
    assign en_acc = en & !clear;
`endif

    always_comb begin
        v1_d     = v1_q;
        eq_d     = eq_q;
        lt_d     = lt_q;
        nonce1_d = nonce1_q;
        hword1_d = hword1_q;
        if (clear) begin
            v1_d = 1'b0;
        end else begin
            v1_d = en_acc;
            if (en_acc) begin
                for (int i = 0; i < N_WORDS; i++) begin
                    eq_d[i] = (vec_i(H, i) == vec_i(target, i));
                    lt_d[i] = (vec_i(H, i) <  vec_i(target, i));
                end
                nonce1_d = nonce;
                hword1_d = vec_i(H, N_WORDS-1);
            end
        end
    end

    always_comb begin
        v2_d     = !clear & v1_q & resolve_hit(eq_q, lt_q);
        entry2_d = {nonce1_q, hword1_q};

        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en_acc && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end

        overflow_d = !clear & (overflow_q | fifo_drop);
    end

`ifdef SHA_TARGET_STOP_ON_HIT_EN
    // Set on the push of the first hit; only clear or reset releases it.
    always_comb begin
        halted_d = !clear & (halted_q | v2_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    assign halted = halted_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1_q       <= 1'b0;
            eq_q       <= '0;
            lt_q       <= '0;
            nonce1_q   <= '0;
            hword1_q   <= '0;
            v2_q       <= 1'b0;
            entry2_q   <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            v1_q       <= v1_d;
            eq_q       <= eq_d;
            lt_q       <= lt_d;
            nonce1_q   <= nonce1_d;
            hword1_q   <= hword1_d;
            v2_q       <= v2_d;
            entry2_q   <= entry2_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
        end
    end

    sha_hit_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (HIT_ENTRY_S)
    ) u_hit_fifo (
        .clk        (clk),
        .rst        (reset),
        .clear      (clear),
        .push       (v2_q),
        .push_data  (entry2_q),
        .pop_ready  (hit_ready),
        .head_valid (hit_valid),
        .head_data  (head_data),
        .drop       (fifo_drop)
    );

    assign hit_nonce  = head_data[HIT_ENTRY_S-1:WORD_S];
    assign hit_hword  = head_data[WORD_S-1:0];
    assign hash_count = cnt_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_sha_target_check.sv
// Bench for sha_target_check: vector table, hand-written corner sequences and
// random traffic, all checked every cycle against a queue-based model.
module tb_sha_target_check;

    localparam int DEPTH = 4;
    localparam int CNT_W = 48;

    logic         clk;
    logic         reset;
    logic         clear;
    logic         en;
    logic [31:0]  nonce;
    logic [255:0] h_in;
    logic [255:0] tgt;
    logic         hit_valid;
    logic         hit_ready;
    logic [31:0]  hit_nonce;
    logic [31:0]  hit_hword;
    logic [47:0]  hash_count;
    logic         overflow;
`ifdef SHA_TARGET_STOP_ON_HIT_EN
    logic         halted;
`endif

    sha_target_check #(
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .en         (en),
        .nonce      (nonce),
        .H          (h_in),
        .target     (tgt),
        .hit_valid  (hit_valid),
        .hit_ready  (hit_ready),
        .hit_nonce  (hit_nonce),
        .hit_hword  (hit_hword),
        .hash_count (hash_count),
`ifdef SHA_TARGET_STOP_ON_HIT_EN
        .halted     (halted),
`endif
        .overflow   (overflow)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Expected FIFO contents are {nonce, H word 7}; a hash is a hit when the
    // 256-bit value H is unsigned <= target, decided at its own en.
    logic [63:0] exp_q[$];
    bit          p1_v, p1_hit, p2_v;
    logic [63:0] p1_e, p2_e;
    logic [47:0] m_cnt;
    bit          m_ovf;
    bit          m_halt;

    task automatic model_reset();
        exp_q.delete();
        p1_v = 0; p1_hit = 0; p2_v = 0;
        p1_e = '0; p2_e = '0;
        m_cnt = '0; m_ovf = 0; m_halt = 0;
    endtask

    task automatic model_edge();
        bit pop, push, acc;
        if (clear) begin
            model_reset();
            return;
        end
        pop  = (exp_q.size() > 0) && hit_ready;
        push = p2_v;
        if (pop) void'(exp_q.pop_front());
        if (push) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(p2_e);
            else m_ovf = 1;
        end
        acc = en;
`ifdef SHA_TARGET_STOP_ON_HIT_EN
        acc = en && !m_halt;
        if (push) m_halt = 1;
`endif
        p2_v = p1_v && p1_hit;
        p2_e = p1_e;
        p1_v = acc;
        if (acc) begin
            p1_hit = (h_in <= tgt);
            p1_e   = {nonce, h_in[255:224]};
            if (m_cnt != 48'hFFFF_FFFF_FFFF) m_cnt = m_cnt + 1;
        end
    endtask

    task automatic check_all();
        check("hit_valid", {63'd0, hit_valid}, {63'd0, exp_q.size() > 0});
        if (exp_q.size() > 0 && hit_valid) begin
            check("hit_nonce", {32'd0, hit_nonce}, {32'd0, exp_q[0][63:32]});
            check("hit_hword", {32'd0, hit_hword}, {32'd0, exp_q[0][31:0]});
        end
        check("hash_count", {16'd0, hash_count}, {16'd0, m_cnt});
        check("overflow", {63'd0, overflow}, {63'd0, m_ovf});
`ifdef SHA_TARGET_STOP_ON_HIT_EN
        check("halted", {63'd0, halted}, {63'd0, m_halt});
`endif
    endtask

    // ---------------- driver ----------------
    task automatic step(input bit e, input logic [31:0] n, input logic [255:0] h,
                        input logic [255:0] t, input bit rdy, input bit clr);
        en = e; nonce = n; h_in = h; tgt = t; hit_ready = rdy; clear = clr;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 32'd0, h_in, tgt, rdy, 1'b0);
    endtask

    typedef struct {
        logic [255:0] h;
        logic [255:0] t;
        logic [31:0]  nonce;
        bit           exp_hit;
    } vec_t;

    vec_t tbl[8];

    logic [255:0] ones;
    logic [255:0] t_a, h_a, h_b, t_r, h_r;
    logic [31:0]  exp_order[4];

    initial begin
        ones = {256{1'b1}};

        tbl[0] = '{h: 256'd0, t: 256'd0, nonce: 32'hA0, exp_hit: 1};
        tbl[1] = '{h: 256'd1, t: 256'd0, nonce: 32'hA1, exp_hit: 0};
        tbl[2] = '{h: ones, t: ones, nonce: 32'hA2, exp_hit: 1};
        tbl[3] = '{h: {32'h1, 224'd0}, t: {32'h0, {224{1'b1}}}, nonce: 32'hA3, exp_hit: 0};
        tbl[4] = '{h: {32'h5, 32'h7, 192'd0}, t: {32'h5, 32'h8, 192'd0}, nonce: 32'hA4, exp_hit: 1};
        tbl[5] = '{h: {32'h5, 32'h9, 192'd0}, t: {32'h5, 32'h8, 192'd0}, nonce: 32'hA5, exp_hit: 0};
        tbl[6] = '{h: {224'd0, 32'h8000_0000}, t: {224'd0, 32'h7FFF_FFFF}, nonce: 32'hA6, exp_hit: 0};
        tbl[7] = '{h: {32'hFFFF_FFFF, 224'd0}, t: {32'hFFFF_FFFF, 224'd1}, nonce: 32'hA7, exp_hit: 1};

        // reset
        reset = 1'b1; clear = 1'b0; en = 1'b0; nonce = '0; h_in = '0; tgt = '0; hit_ready = 1'b0;
        model_reset();
        #12;
        check("rst_hit_valid", {63'd0, hit_valid}, 64'd0);
        check("rst_hit_nonce", {32'd0, hit_nonce}, 64'd0);
        check("rst_hit_hword", {32'd0, hit_hword}, 64'd0);
        check("rst_hash_count", {16'd0, hash_count}, 64'd0);
        check("rst_overflow", {63'd0, overflow}, 64'd0);
        #10;
        reset = 1'b0;

        // hit, miss, boundary and latency
        t_a = {32'h0, 32'hFFFF_FFFF, 192'd0};
        h_a = {32'h0, 32'h1, 192'd0};
        h_b = {32'h1, 224'd0};
        step(1'b1, 32'h11, h_a, t_a, 1'b0, 1'b0);
        step(1'b1, 32'h22, h_b, t_a, 1'b0, 1'b0);
        check("lat_not_before_n3", {63'd0, hit_valid}, 64'd0);
        idle(1'b0);
        check("lat_valid_n3", {63'd0, hit_valid}, 64'd1);
        check("hit1_nonce", {32'd0, hit_nonce}, 64'h11);
        check("hit1_hword", {32'd0, hit_hword}, 64'h0);
        idle(1'b0);
        idle(1'b0);
        check("hit1_count", {16'd0, hash_count}, 64'd2);
        idle(1'b1);
        check("miss_not_pushed", {63'd0, hit_valid}, 64'd0);

        // equality
        t_r = {8{32'hDEAD_BEEF}};
        step(1'b1, 32'hDEAD_BEEF, t_r, t_r, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        check("eq_valid", {63'd0, hit_valid}, 64'd1);
        check("eq_nonce", {32'd0, hit_nonce}, 64'hDEAD_BEEF);
        idle(1'b1);

        // vector table
        for (int i = 0; i < 8; i++) begin
            step(1'b1, tbl[i].nonce, tbl[i].h, tbl[i].t, 1'b0, 1'b0);
            idle(1'b0);
            idle(1'b0);
            check("tbl_hit", {63'd0, hit_valid}, {63'd0, tbl[i].exp_hit});
            if (tbl[i].exp_hit)
                check("tbl_nonce", {32'd0, hit_nonce}, {32'd0, tbl[i].nonce});
            idle(1'b1);
        end

        // back-pressure and overflow
        step(1'b0, 32'd0, h_in, tgt, 1'b0, 1'b1);
        for (int i = 1; i <= 5; i++)
            step(1'b1, 32'(i), 256'd0, ones, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        check("bp_overflow", {63'd0, overflow}, 64'd1);
        for (int i = 1; i <= 4; i++) begin
            check("bp_order", {32'd0, hit_nonce}, 64'(i));
            idle(1'b1);
        end
        check("bp_empty", {63'd0, hit_valid}, 64'd0);

        // simultaneous push and pop on a full FIFO
        step(1'b0, 32'd0, h_in, tgt, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++)
            step(1'b1, 32'(i), 256'd0, ones, 1'b0, 1'b0);
        step(1'b1, 32'd9, 256'd0, ones, 1'b0, 1'b0);
        idle(1'b0);
        check("full_head", {32'd0, hit_nonce}, 64'd1);
        idle(1'b1);
        check("full_no_ovf", {63'd0, overflow}, 64'd0);
        exp_order[0] = 32'd2; exp_order[1] = 32'd3; exp_order[2] = 32'd4; exp_order[3] = 32'd9;
        for (int i = 0; i < 4; i++) begin
            check("full_order", {32'd0, hit_nonce}, {32'd0, exp_order[i]});
            idle(1'b1);
        end
        check("full_empty", {63'd0, hit_valid}, 64'd0);

        // clear together with en while two hits are in flight
        step(1'b1, 32'h31, 256'd0, ones, 1'b0, 1'b0);
        step(1'b1, 32'h32, 256'd0, ones, 1'b0, 1'b0);
        step(1'b1, 32'h33, 256'd0, ones, 1'b0, 1'b1);
        check("clr_count", {16'd0, hash_count}, 64'd0);
        check("clr_valid", {63'd0, hit_valid}, 64'd0);
        for (int i = 0; i < 3; i++) idle(1'b0);
        check("clr_no_late_push", {63'd0, hit_valid}, 64'd0);

        // asynchronous reset mid-cycle
        step(1'b1, 32'h41, 256'd0, ones, 1'b0, 1'b0);
        step(1'b1, 32'h42, 256'd0, ones, 1'b0, 1'b0);
        en = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check("arst_count", {16'd0, hash_count}, 64'd0);
        check("arst_valid", {63'd0, hit_valid}, 64'd0);
        check("arst_overflow", {63'd0, overflow}, 64'd0);
        #10;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) idle(1'b0);
        check("arst_no_late_push", {63'd0, hit_valid}, 64'd0);

        // halt-on-hit run: only nonce 3 hits among ten hashes
        step(1'b0, 32'd0, h_in, tgt, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++)
            step(1'b1, 32'(i), (i == 3) ? 256'd0 : ones, {1'b0, {255{1'b1}}}, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b1);
`ifdef SHA_TARGET_STOP_ON_HIT_EN
        check("halt_flag", {63'd0, halted}, 64'd1);
        check("halt_count", {16'd0, hash_count}, 64'd6);
        step(1'b0, 32'd0, h_in, tgt, 1'b1, 1'b1);
        check("halt_released", {63'd0, halted}, 64'd0);
`else
        check("run_count", {16'd0, hash_count}, 64'd10);
`endif
        step(1'b0, 32'd0, h_in, tgt, 1'b1, 1'b1);

        // random traffic against the model
        for (int c = 0; c < 400; c++) begin
            int w;
            t_r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            h_r = t_r;
            w = $urandom_range(0, 7);
            if ($urandom_range(0, 4) != 0) begin
                h_r[w*32 +: 32] = t_r[w*32 +: 32] + 32'($urandom_range(0, 2)) - 32'd1;
                for (int j = 0; j < w; j++) h_r[j*32 +: 32] = $urandom;
            end
            step($urandom_range(0, 3) != 0, $urandom, h_r, t_r,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 59) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
